// File: rtl/inst_ser_pkg.sv
// Shared types and sizing helpers for the instruction bundle serializer.
package inst_ser_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam int unsigned DEF_INST_W  = 32;
  localparam int unsigned DEF_PC_STEP = 4;

  // Width needed to encode a slot count in 0..slots.
  function automatic int unsigned cnt_width(input int unsigned slots);
    return unsigned'($clog2(slots + 1));
  endfunction

  // Slot index width, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned slots);
    return (slots > 1) ? unsigned'($clog2(slots)) : 1;
  endfunction

endpackage

// File: rtl/inst_bundle_serializer.sv
// Serializes a fetch bundle of up to SLOTS instructions into a one-per-cycle
// stream tagged with PC and last flag, with zero-bubble bundle chaining.
module inst_bundle_serializer
  import inst_ser_pkg::*;
#(
  parameter int unsigned SLOTS   = 2,
  parameter int unsigned INST_W  = DEF_INST_W,
  parameter int unsigned PC_W    = 32,
  parameter int unsigned PC_STEP = DEF_PC_STEP
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [SLOTS*INST_W-1:0]     in_bundle,
  input  logic [cnt_width(SLOTS)-1:0] in_count,
  input  logic [PC_W-1:0]             in_pc,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [INST_W-1:0]           out_inst,
  output logic [PC_W-1:0]             out_pc,
  output logic                        out_last,
  output logic                        busy
);

  localparam int unsigned CNT_W = cnt_width(SLOTS);
  localparam int unsigned IDX_W = idx_width(SLOTS);

  localparam logic [0:0] ST_IDLE = IDLE;
  localparam logic [0:0] ST_BUSY = BUSY;

  logic [0:0]              state_q, state_d;
  logic [SLOTS*INST_W-1:0] bundle_q, bundle_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [PC_W-1:0]         pc_q, pc_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    out_valid_d;
  logic [INST_W-1:0]       out_inst_d;
  logic [PC_W-1:0]         out_pc_d;
  logic                    out_last_d;

  logic                    cap;
  logic                    iss;
  logic [CNT_W-1:0]        eff_count;
  logic [IDX_W-1:0]        idx_nx;

  // A new bundle may enter while idle or as the final slot drains.
  always_comb begin
    in_ready  = !reset && !flush &&
                (state_q == ST_IDLE || (out_valid && out_ready && out_last));
    eff_count = (in_count > CNT_W'(SLOTS)) ? CNT_W'(SLOTS) : in_count;
    cap       = in_valid && in_ready;
    iss       = out_valid && out_ready;
    idx_nx    = idx_q + IDX_W'(1);
  end

  assign busy = (state_q == ST_BUSY);

  // Next-state and next-output logic; flush overrides issue and capture.
  always_comb begin
    state_d     = state_q;
    bundle_d    = bundle_q;
    count_d     = count_q;
    pc_d        = pc_q;
    idx_d       = idx_q;
    out_valid_d = out_valid;
    out_inst_d  = out_inst;
    out_pc_d    = out_pc;
    out_last_d  = out_last;

    if (flush) begin
      state_d     = ST_IDLE;
      out_valid_d = 1'b0;
      idx_d       = '0;
    end else begin
      if (iss) begin
        if (out_last) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
        end else begin
          idx_d      = idx_nx;
          out_inst_d = bundle_q[int'(idx_nx)*INST_W +: INST_W];
          out_pc_d   = pc_q + PC_W'(idx_nx) * PC_W'(PC_STEP);
          out_last_d = (CNT_W'(idx_nx) == count_q - CNT_W'(1));
        end
      end
      if (cap) begin
        bundle_d = in_bundle;
        count_d  = eff_count;
        pc_d     = in_pc;
        idx_d    = '0;
        if (eff_count != '0) begin
          state_d     = ST_BUSY;
          out_valid_d = 1'b1;
          out_inst_d  = in_bundle[INST_W-1:0];
          out_pc_d    = in_pc;
          out_last_d  = (eff_count == CNT_W'(1));
        end else begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      bundle_q  <= '0;
      count_q   <= '0;
      pc_q      <= '0;
      idx_q     <= '0;
      out_valid <= 1'b0;
      out_inst  <= '0;
      out_pc    <= '0;
      out_last  <= 1'b0;
    end else begin
      state_q   <= state_d;
      bundle_q  <= bundle_d;
      count_q   <= count_d;
      pc_q      <= pc_d;
      idx_q     <= idx_d;
      out_valid <= out_valid_d;
      out_inst  <= out_inst_d;
      out_pc    <= out_pc_d;
      out_last  <= out_last_d;
    end
  end

  // Oversized counts are clamped to SLOTS; flag them in simulation.
  always_ff @(posedge clk) begin
    if (!reset && in_valid && in_ready)
      assert (in_count <= CNT_W'(SLOTS))
      else $warning("in_count %0d above SLOTS, clamped", in_count);
  end

endmodule

// File: tb/tb_inst_bundle_serializer.sv
// Bench for inst_bundle_serializer: directed scenarios plus random traffic
// on a 2-slot and a 4-slot instance, checked against a queue-based model.
module tb_inst_bundle_serializer;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        last;
  } item_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // 2-slot instance signals
  logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [63:0] a_bundle;
  logic [1:0]  a_count;
  logic [31:0] a_pc, a_out_inst, a_out_pc;
  logic        a_out_last, a_busy;

  // 4-slot instance signals
  logic         b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [127:0] b_bundle;
  logic [2:0]   b_count;
  logic [31:0]  b_pc, b_out_inst, b_out_pc;
  logic         b_out_last, b_busy;

  int total = 0;
  int bad   = 0;
  item_t q2[$];
  item_t q4[$];

  inst_bundle_serializer #(.SLOTS(2)) dut2 (
    .clk(clk), .reset(reset), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_bundle(a_bundle),
    .in_count(a_count), .in_pc(a_pc),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_inst(a_out_inst),
    .out_pc(a_out_pc), .out_last(a_out_last), .busy(a_busy)
  );

  inst_bundle_serializer #(.SLOTS(4)) dut4 (
    .clk(clk), .reset(reset), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_bundle(b_bundle),
    .in_count(b_count), .in_pc(b_pc),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_inst(b_out_inst),
    .out_pc(b_out_pc), .out_last(b_out_last), .busy(b_busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare one instance against its pending-output queue, then advance the queue
  // by what the upcoming clock edge does.
  task automatic model_cycle(input int d);
    item_t          q[$];
    logic [127:0]   bun;
    int unsigned    cnt, slots, n;
    logic [31:0]    pc, oi, op;
    logic           iv, fl, ordy, rdy, ov, ol, bz, exp_rdy;
    string          nm;
    if (d == 0) begin
      nm = "s2"; slots = 2; q = q2;
      bun = {64'b0, a_bundle}; cnt = a_count; pc = a_pc; iv = a_in_valid;
      fl = a_flush; ordy = a_out_ready; rdy = a_in_ready; ov = a_out_valid;
      oi = a_out_inst; op = a_out_pc; ol = a_out_last; bz = a_busy;
    end else begin
      nm = "s4"; slots = 4; q = q4;
      bun = b_bundle; cnt = b_count; pc = b_pc; iv = b_in_valid;
      fl = b_flush; ordy = b_out_ready; rdy = b_in_ready; ov = b_out_valid;
      oi = b_out_inst; op = b_out_pc; ol = b_out_last; bz = b_busy;
    end
    exp_rdy = !reset && !fl && (q.size() == 0 || (ordy && q.size() == 1));
    chk({nm, " in_ready"}, rdy, exp_rdy);
    chk({nm, " out_valid"}, ov, q.size() != 0);
    chk({nm, " busy"}, bz, q.size() != 0);
    if (q.size() != 0) begin
      chk({nm, " out_inst"}, oi, q[0].inst);
      chk({nm, " out_pc"}, op, q[0].pc);
      chk({nm, " out_last"}, ol, q[0].last);
    end
    if (reset || fl) begin
      q.delete();
    end else begin
      if (q.size() != 0 && ordy) q.delete(0);
      if (iv && exp_rdy) begin
        n = (cnt > slots) ? slots : cnt;
        for (int unsigned k = 0; k < n; k++)
          q.push_back('{inst: bun[k*32 +: 32], pc: pc + 32'(k * 4), last: (k == n - 1)});
      end
    end
    if (d == 0) q2 = q; else q4 = q;
  endtask

  task automatic step();
    #1;
    model_cycle(0);
    model_cycle(1);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] wrap_pc [4];
    wrap_pc[0] = 32'hFFFF_FFF8; wrap_pc[1] = 32'hFFFF_FFFC;
    wrap_pc[2] = 32'h0000_0000; wrap_pc[3] = 32'h0000_0004;

    reset = 1'b1;
    a_flush = 0; a_in_valid = 0; a_out_ready = 1; a_bundle = '0; a_count = 0; a_pc = 0;
    b_flush = 0; b_in_valid = 0; b_out_ready = 1; b_bundle = '0; b_count = 0; b_pc = 0;
    @(negedge clk);
    step();
    step();
    reset = 1'b0;
    chk("reset out_inst", a_out_inst, 0);
    chk("reset out_pc", a_out_pc, 0);
    chk("reset out_last", a_out_last, 0);
    chk("reset s4 out_inst", b_out_inst, 0);

    // basic two-slot bundle
    a_bundle = {32'hBBBB_0002, 32'hAAAA_0001}; a_count = 2; a_pc = 32'h1000; a_in_valid = 1;
    step();
    a_in_valid = 0;
    chk("t1 slot0 inst", a_out_inst, 32'hAAAA_0001);
    chk("t1 slot0 pc", a_out_pc, 32'h1000);
    chk("t1 slot0 last", a_out_last, 0);
    step();
    chk("t1 slot1 inst", a_out_inst, 32'hBBBB_0002);
    chk("t1 slot1 pc", a_out_pc, 32'h1004);
    chk("t1 slot1 last", a_out_last, 1);
    step();
    chk("t1 idle", a_out_valid, 0);

    // back-to-back bundles, no bubble
    a_bundle = {32'h2222_0002, 32'h2222_0001}; a_pc = 32'h2000; a_in_valid = 1;
    step();
    chk("b2b out_valid a0", a_out_valid, 1);
    step();
    a_bundle = {32'h3333_0002, 32'h3333_0001}; a_pc = 32'h3000;
    #1 chk("b2b in_ready on drain", a_in_ready, 1);
    step();
    a_in_valid = 0;
    for (int i = 0; i < 2; i++) begin
      chk("b2b out_valid", a_out_valid, 1);
      step();
    end
    chk("b2b end idle", a_out_valid, 0);

    // downstream back-pressure mid-bundle
    a_bundle = {32'h4444_0002, 32'h4444_0001}; a_pc = 32'h4000; a_in_valid = 1;
    step();
    a_out_ready = 0; a_pc = 32'h5000;
    for (int i = 0; i < 3; i++) begin
      #1 chk("stall in_ready", a_in_ready, 0);
      chk("stall inst", a_out_inst, 32'h4444_0001);
      step();
    end
    a_out_ready = 1; a_in_valid = 0;
    step();
    chk("stall release inst", a_out_inst, 32'h4444_0002);
    step();
    step();

    // count=1 then count=0 accepted on the drain cycle
    a_bundle = {32'hDEAD_0000, 32'h1111_0011}; a_count = 1; a_pc = 32'h6000; a_in_valid = 1;
    step();
    chk("cnt1 last", a_out_last, 1);
    a_count = 0;
    #1 chk("cnt0 in_ready", a_in_ready, 1);
    step();
    chk("cnt0 no out_valid", a_out_valid, 0);
    chk("cnt0 busy", a_busy, 0);
    a_in_valid = 0;
    step();
    chk("cnt0 still idle", a_out_valid, 0);

    // flush while slot 0 stalls, with a concurrent offer
    a_bundle = {32'h8888_0002, 32'h8888_0001}; a_count = 2; a_pc = 32'h7000; a_in_valid = 1;
    step();
    a_out_ready = 0; a_in_valid = 0;
    step();
    a_flush = 1; a_in_valid = 1; a_pc = 32'h7100;
    #1 chk("flush in_ready", a_in_ready, 0);
    step();
    a_flush = 0; a_in_valid = 0; a_out_ready = 1;
    chk("flush out_valid", a_out_valid, 0);
    chk("flush busy", a_busy, 0);
    step();
    chk("flush no capture", a_out_valid, 0);

    // oversized count clamps to SLOTS
    a_bundle = {32'h9999_0002, 32'h9999_0001}; a_count = 3; a_pc = 32'h8000; a_in_valid = 1;
    step();
    a_in_valid = 0;
    step();
    chk("clamp last", a_out_last, 1);
    step();
    chk("clamp idle", a_out_valid, 0);

    // 4-slot PC wrap
    b_bundle = {32'hD4, 32'hC3, 32'hB2, 32'hA1}; b_count = 4; b_pc = 32'hFFFF_FFF8; b_in_valid = 1;
    step();
    b_in_valid = 0;
    for (int k = 0; k < 4; k++) begin
      chk("wrap pc", b_out_pc, wrap_pc[k]);
      chk("wrap last", b_out_last, k == 3);
      step();
    end
    chk("wrap idle", b_out_valid, 0);

    // random traffic on both instances
    for (int i = 0; i < 400; i++) begin
      a_in_valid = 1'($urandom % 2);
      a_count = 2'($urandom_range(0, 2));
      a_bundle = {$urandom, $urandom};
      a_pc = $urandom;
      a_out_ready = ($urandom % 4) != 0;
      a_flush = ($urandom % 16) == 0;
      b_in_valid = 1'($urandom % 2);
      b_count = 3'($urandom_range(0, 4));
      b_bundle = {$urandom, $urandom, $urandom, $urandom};
      b_pc = $urandom;
      b_out_ready = ($urandom % 3) != 0;
      b_flush = ($urandom % 16) == 0;
      step();
    end

    // reset in the middle of a held bundle
    a_flush = 1; b_flush = 1; a_in_valid = 0; b_in_valid = 0; a_out_ready = 1; b_out_ready = 1;
    step();
    a_flush = 0; b_flush = 0;
    a_bundle = {32'h5555_0002, 32'h5555_0001}; a_count = 2; a_pc = 32'h9000; a_in_valid = 1;
    step();
    a_in_valid = 0; a_out_ready = 0;
    step();
    chk("pre-reset held", a_out_valid, 1);
    reset = 1;
    step();
    reset = 0; a_out_ready = 1;
    chk("midreset out_valid", a_out_valid, 0);
    chk("midreset out_inst", a_out_inst, 0);
    chk("midreset out_pc", a_out_pc, 0);
    chk("midreset out_last", a_out_last, 0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
